conv_layer_sched: RTL and testbench
===================================

// Module: conv_layer_sched
// PURPOSE
//  Control sequencer for the image CONV engine. Walks a 2^IMG_LOG2 square greyscale image.
//  Issues 3x3 zero-padded window fetches and MAC strobes to the external conv/ReLU datapath,
//  then schedules layer-0 writes. Afterwards it reads layer 0 back in 2x2 blocks,
//  drives max-pool strobes, and schedules layer-1 writes.
//  Holds no pixel data; cdata_wr is sourced by the datapath.
// PARAMETERS
//  IMG_LOG2   6    log2 of image width/height (64x64)
//  ADDR_W     12   address width, = 2*IMG_LOG2
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  ready      in   1       start request, sampled only in IDLE
//  busy       out  1       high from start until last layer-1 write completes
//  iaddr      out  ADDR_W  image read address; idata valid next cycle
//  pad        out  1       tap aligned with mac_en lies outside image (datapath uses 0)
//  tap_idx    out  4       kernel index 0..8 aligned with mac_en (weight select)
//  mac_clr    out  1       clear accumulator, aligned with tap 0 mac_en
//  mac_en     out  1       accumulate idata*w[tap_idx] (or 0 if pad)
//  pool_clr   out  1       load max register, aligned with first pool_en
//  pool_en    out  1       cdata_rd valid, compare into max register
//  crd        out  1       layer-memory read strobe
//  caddr_rd   out  ADDR_W  layer-memory read address; cdata_rd valid next cycle
//  cwr        out  1       layer-memory write strobe
//  caddr_wr   out  ADDR_W  layer-memory write address
//  csel       out  3       000 none, 001 layer0, 011 layer1
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=IDLE, all outputs and counters 0.
//  FSM: IDLE -> C_FETCH -> C_LAST -> C_WB -> (C_FETCH | P_RD) ; P_RD -> P_LAST -> P_WB -> (P_RD | IDLE)
//  IDLE: ready=1 at edge -> C_FETCH, busy=1 from that edge; ready ignored while busy.
//  C_FETCH: 9 cycles, tap k=0..8, dr=k/3-1, dc=k%3-1 around pixel (r,c).
//    iaddr=(r+dr)*W+(c+dc) if inside image; else iaddr=0 with pad flagged.
//  Strobe registers: mac_en/tap_idx/pad/mac_clr are issue-cycle values delayed 1 cycle.
//    mac_en high C_FETCH cycles 2..9 and C_LAST; mac_clr only with tap 0.
//  C_WB: 1 cycle cwr=1, csel=001, caddr_wr=r*W+c. Then advance c, wrapping to r+1.
//    After pixel W*W-1 -> P_RD. Cost is 11 cycles/pixel.
//  P_RD: 4 cycles crd=1, csel=001, caddr_rd order (2i,2j),(2i,2j+1),(2i+1,2j),(2i+1,2j+1).
//    pool_en is crd delayed 1; pool_clr with the first read only.
//  P_LAST: pool_en for 4th read. P_WB: cwr=1, csel=011, caddr_wr=i*(W/2)+j.
//    Cost is 6 cycles/output; after output (W/2)^2-1, busy=0 on the next edge -> IDLE.
//  Outside listed cycles: cwr=crd=mac_en=pool_en=0, csel=000, addresses hold last value.
//  Counters are unsigned. Boundary checks use r-1<0 / r+1>W-1 compares before address forming.
//    No wrap-around aliasing is permitted: column -1 must never map to previous row.
//  cwr and crd never high in the same cycle.
// TESTING
//  1 Reset: reset=0 mid-C_FETCH -> next sample busy=0, cwr=crd=mac_en=0, csel=000, FSM IDLE.
//  2 Corner (0,0): ready pulse at edge 0.
//    -> taps 0,1,2,3,6 pad=1; taps 4,5,7,8 iaddr=0,1,64,65.
//    -> cwr at cycle 11 with caddr_wr=0, csel=001.
//  3 Edge (0,63): taps 2,5,8 pad=1 (no wrap to col 0). (63,63): iaddr 4030,4031,4094,4095 for taps 0,1,3,4.
//  4 Pool: first block reads 0,1,64,65 -> pool_clr with 1st pool_en, P_WB caddr_wr=0, csel=011.
//    Last block reads 4030,4031,4094,4095 -> caddr_wr=1023.
//  5 Full frame: busy high exactly 45056+6144=51200 cycles.
//    4096 layer-0 writes and 1024 layer-1 writes, each address written once, in ascending order.
//  6 ready held high during and after the frame -> no restart while busy; new frame starts the edge after return to IDLE.

Source files
------------

// File: rtl/conv_layer_sched.sv
// Sequencer for the image CONV engine: 3x3 conv fetch/MAC, layer-0 writes, then 2x2 max-pool and layer-1 writes.
// Latency: addresses and write/read strobes follow state combinationally; MAC/pool strobes lag their issue by 1 cycle.
// No backpressure: once started, runs 11 cycles/pixel then 6 cycles/pool output; ready is ignored while busy.
module conv_layer_sched #(
  parameter int IMG_LOG2 = 6,
  parameter int ADDR_W   = 2 * IMG_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic              pad,
  output logic [3:0]        tap_idx,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              pool_clr,
  output logic              pool_en,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [2:0]        csel
);

  localparam int PW = IMG_LOG2 - 1;
  localparam logic [IMG_LOG2-1:0] ONE_RC = 1;
  localparam logic [PW-1:0]       ONE_P  = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    C_FETCH = 3'd1,
    C_LAST  = 3'd2,
    C_WB    = 3'd3,
    P_RD    = 3'd4,
    P_LAST  = 3'd5,
    P_WB    = 3'd6
  } state_t;

  state_t state_q, state_d;

  // Conv position (row, col), kernel tap, pool block (i, j) and read index within the block.
  logic [IMG_LOG2-1:0] r_q, r_d, c_q, c_d;
  logic [3:0]          k_q, k_d;
  logic [PW-1:0]       i_q, i_d, j_q, j_d;
  logic [1:0]          q_q, q_d;

  // Address holding registers and delayed datapath strobes.
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
  logic              mac_en_q, mac_en_d;
  logic              mac_clr_q, mac_clr_d;
  logic              pad_q, pad_d;
  logic [3:0]        tap_idx_q, tap_idx_d;
  logic              pool_en_q, pool_en_d;
  logic              pool_clr_q, pool_clr_d;

  // Tap geometry: kr/kc are kernel row/col 0..2, i.e. offset +1.
  logic [1:0]          kr, kc;
  logic [IMG_LOG2-1:0] tap_row, tap_col;
  logic                tap_pad;
  logic [ADDR_W-1:0]   tap_addr;
  logic                pix_last, blk_last;

  assign pix_last = (r_q == '1) && (c_q == '1);
  assign blk_last = (i_q == '1) && (j_q == '1);

  // Split the tap index into kernel row/col and form the bounds-checked image address.
  always_comb begin
    kr = 2'd0;
    kc = 2'd0;
    case (k_q)
      4'd0: begin kr = 2'd0; kc = 2'd0; end
      4'd1: begin kr = 2'd0; kc = 2'd1; end
      4'd2: begin kr = 2'd0; kc = 2'd2; end
      4'd3: begin kr = 2'd1; kc = 2'd0; end
      4'd4: begin kr = 2'd1; kc = 2'd1; end
      4'd5: begin kr = 2'd1; kc = 2'd2; end
      4'd6: begin kr = 2'd2; kc = 2'd0; end
      4'd7: begin kr = 2'd2; kc = 2'd1; end
      4'd8: begin kr = 2'd2; kc = 2'd2; end
      default: begin kr = 2'd0; kc = 2'd0; end
    endcase
    // Edge tests are done on the unmodified counters so a -1/+1 never wraps into a neighbour row/col.
    tap_pad = ((kr == 2'd0) && (r_q == '0)) || ((kr == 2'd2) && (r_q == '1)) ||
              ((kc == 2'd0) && (c_q == '0)) || ((kc == 2'd2) && (c_q == '1));
    tap_row = (kr == 2'd0) ? (r_q - ONE_RC) : ((kr == 2'd2) ? (r_q + ONE_RC) : r_q);
    tap_col = (kc == 2'd0) ? (c_q - ONE_RC) : ((kc == 2'd2) ? (c_q + ONE_RC) : c_q);
    tap_addr = tap_pad ? '0 : ADDR_W'({tap_row, tap_col});
  end

  // State, counters and output holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      q_q        <= '0;
      iaddr_q    <= '0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      pad_q      <= 1'b0;
      tap_idx_q  <= '0;
      pool_en_q  <= 1'b0;
      pool_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      i_q        <= i_d;
      j_q        <= j_d;
      q_q        <= q_d;
      iaddr_q    <= iaddr_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      mac_en_q   <= mac_en_d;
      mac_clr_q  <= mac_clr_d;
      pad_q      <= pad_d;
      tap_idx_q  <= tap_idx_d;
      pool_en_q  <= pool_en_d;
      pool_clr_q <= pool_clr_d;
    end
  end

  // Next state and counter advance.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (ready) begin
          state_d = C_FETCH;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          i_d     = '0;
          j_d     = '0;
          q_d     = '0;
        end
      end
      C_FETCH: begin
        if (k_q == 4'd8) begin
          state_d = C_LAST;
          k_d     = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      C_LAST: state_d = C_WB;
      C_WB: begin
        // Row/col both wrap to 0 after the last pixel, ready for the next frame.
        c_d = c_q + ONE_RC;
        if (c_q == '1) r_d = r_q + ONE_RC;
        state_d = pix_last ? P_RD : C_FETCH;
      end
      P_RD: begin
        if (q_q == 2'd3) begin
          state_d = P_LAST;
          q_d     = '0;
        end else begin
          q_d = q_q + 2'd1;
        end
      end
      P_LAST: state_d = P_WB;
      P_WB: begin
        j_d = j_q + ONE_P;
        if (j_q == '1) i_d = i_q + ONE_P;
        state_d = blk_last ? IDLE : P_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state outputs; addresses hold their last value outside the states that drive them.
  always_comb begin
    busy       = (state_q != IDLE);
    cwr        = 1'b0;
    crd        = 1'b0;
    csel       = 3'b000;
    iaddr_d    = iaddr_q;
    caddr_rd_d = caddr_rd_q;
    caddr_wr_d = caddr_wr_q;
    mac_en_d   = 1'b0;
    mac_clr_d  = 1'b0;
    pad_d      = 1'b0;
    tap_idx_d  = '0;
    pool_en_d  = 1'b0;
    pool_clr_d = 1'b0;
    case (state_q)
      C_FETCH: begin
        iaddr_d   = tap_addr;
        mac_en_d  = 1'b1;
        mac_clr_d = (k_q == 4'd0);
        pad_d     = tap_pad;
        tap_idx_d = k_q;
      end
      C_WB: begin
        cwr        = 1'b1;
        csel       = 3'b001;
        caddr_wr_d = ADDR_W'({r_q, c_q});
      end
      P_RD: begin
        crd        = 1'b1;
        csel       = 3'b001;
        caddr_rd_d = ADDR_W'({i_q, q_q[1], j_q, q_q[0]});
        pool_en_d  = 1'b1;
        pool_clr_d = (q_q == 2'd0);
      end
      P_WB: begin
        cwr        = 1'b1;
        csel       = 3'b011;
        caddr_wr_d = ADDR_W'({i_q, j_q});
      end
      default: ;
    endcase
  end

  assign iaddr    = iaddr_d;
  assign caddr_rd = caddr_rd_d;
  assign caddr_wr = caddr_wr_d;
  assign mac_en   = mac_en_q;
  assign mac_clr  = mac_clr_q;
  assign pad      = pad_q;
  assign tap_idx  = tap_idx_q;
  assign pool_en  = pool_en_q;
  assign pool_clr = pool_clr_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: window taps, layer-0/1 writes, full-frame counts, restart and async reset.
// Edge numbering: edge 0 is the clock edge that samples ready and starts the frame; values read 1ns after edges.
// A negedge monitor tallies strobes and write ordering over the first frame.
module tb_conv_layer_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic        pad;
  logic [3:0]  tap_idx;
  logic        mac_clr;
  logic        mac_en;
  logic        pool_clr;
  logic        pool_en;
  logic        crd;
  logic [11:0] caddr_rd;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [2:0]  csel;

  always #5 clk = ~clk;

  conv_layer_sched #(.IMG_LOG2(6), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .iaddr(iaddr), .pad(pad), .tap_idx(tap_idx), .mac_clr(mac_clr), .mac_en(mac_en),
    .pool_clr(pool_clr), .pool_en(pool_en), .crd(crd), .caddr_rd(caddr_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .csel(csel)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = -100;

  // Frame-1 tallies.
  logic mon_en = 1'b0;
  int busy_cnt = 0, mac_cnt = 0, mclr_cnt = 0, pool_cnt = 0, pclr_cnt = 0;
  int l0_cnt = 0, l0_err = 0, l1_cnt = 0, l1_err = 0, proto_err = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy)     busy_cnt <= busy_cnt + 1;
      if (mac_en)   mac_cnt  <= mac_cnt + 1;
      if (mac_clr)  mclr_cnt <= mclr_cnt + 1;
      if (pool_en)  pool_cnt <= pool_cnt + 1;
      if (pool_clr) pclr_cnt <= pclr_cnt + 1;
      if (cwr && crd) proto_err <= proto_err + 1;
      if (cwr && csel == 3'b001) begin
        if (caddr_wr != l0_cnt[11:0]) l0_err <= l0_err + 1;
        l0_cnt <= l0_cnt + 1;
      end else if (cwr && csel == 3'b011) begin
        if (caddr_wr != l1_cnt[11:0]) l1_err <= l1_err + 1;
        l1_cnt <= l1_cnt + 1;
      end else if (cwr) begin
        proto_err <= proto_err + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_edge(input int e);
    while (cyc < e) step();
  endtask

  // Pixel p issues tap t at edge 11p+t; its strobes appear one edge later; write at 11p+10.
  task automatic check_pixel(input string nm, input int p, input logic [8:0] pexp, input int aexp[9]);
    for (int t = 0; t < 9; t++) begin
      goto_edge(11 * p + t);
      chk($sformatf("%s iaddr t%0d", nm, t), iaddr, aexp[t]);
      goto_edge(11 * p + t + 1);
      chk($sformatf("%s pad t%0d", nm, t), pad, pexp[t]);
      chk($sformatf("%s tap_idx t%0d", nm, t), tap_idx, t);
      chk($sformatf("%s mac_en t%0d", nm, t), mac_en, 1);
      chk($sformatf("%s mac_clr t%0d", nm, t), mac_clr, (t == 0));
    end
    goto_edge(11 * p + 10);
    chk($sformatf("%s wb cwr", nm), cwr, 1);
    chk($sformatf("%s wb csel", nm), csel, 3'b001);
    chk($sformatf("%s wb caddr_wr", nm), caddr_wr, p);
    chk($sformatf("%s wb mac_en", nm), mac_en, 0);
  endtask

  // Pool block b starts at edge 45056+6b: 4 reads, P_LAST, then the layer-1 write.
  task automatic check_block(input string nm, input int b, input int aexp[4]);
    int e;
    e = 45056 + 6 * b;
    for (int q = 0; q < 4; q++) begin
      goto_edge(e + q);
      chk($sformatf("%s crd r%0d", nm, q), crd, 1);
      chk($sformatf("%s cwr r%0d", nm, q), cwr, 0);
      chk($sformatf("%s csel r%0d", nm, q), csel, 3'b001);
      chk($sformatf("%s caddr_rd r%0d", nm, q), caddr_rd, aexp[q]);
      goto_edge(e + q + 1);
      chk($sformatf("%s pool_en r%0d", nm, q), pool_en, 1);
      chk($sformatf("%s pool_clr r%0d", nm, q), pool_clr, (q == 0));
    end
    chk($sformatf("%s last crd", nm), crd, 0);
    chk($sformatf("%s last csel", nm), csel, 3'b000);
    goto_edge(e + 5);
    chk($sformatf("%s wb cwr", nm), cwr, 1);
    chk($sformatf("%s wb csel", nm), csel, 3'b011);
    chk($sformatf("%s wb caddr_wr", nm), caddr_wr, b);
    chk($sformatf("%s wb pool_en", nm), pool_en, 0);
  endtask

  initial begin
    int a9[9];
    int a4[4];
    int f0;
    int g0;

    reset = 1'b0;
    ready = 1'b0;
    #12;
    chk("rst busy", busy, 0);
    chk("rst cwr", cwr, 0);
    chk("rst crd", crd, 0);
    chk("rst mac_en", mac_en, 0);
    chk("rst csel", csel, 0);
    chk("rst iaddr", iaddr, 0);
    chk("rst caddr_wr", caddr_wr, 0);

    reset = 1'b1;
    step();
    step();
    chk("idle busy", busy, 0);

    // Frame 1; ready stays high throughout so it must be ignored while busy.
    cyc    = -1;
    ready  = 1'b1;
    mon_en = 1'b1;
    step();
    chk("start busy", busy, 1);

    a9 = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
    check_pixel("px0_0", 0, 9'b001001111, a9);
    a9 = '{0, 0, 0, 62, 63, 0, 126, 127, 0};
    check_pixel("px0_63", 63, 9'b100100111, a9);
    a9 = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
    check_pixel("px1_1", 65, 9'b000000000, a9);
    a9 = '{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0};
    check_pixel("px63_63", 4095, 9'b111100100, a9);

    a4 = '{0, 1, 64, 65};
    check_block("blk0", 0, a4);
    a4 = '{2, 3, 66, 67};
    check_block("blk1", 1, a4);
    a4 = '{130, 131, 194, 195};
    check_block("blk33", 33, a4);
    a4 = '{4030, 4031, 4094, 4095};
    check_block("blk1023", 1023, a4);

    goto_edge(51199);
    chk("end busy hi", busy, 1);
    goto_edge(51200);
    chk("end busy lo", busy, 0);
    chk("end cwr", cwr, 0);
    chk("end csel", csel, 0);
    mon_en = 1'b0;
    chk("busy cycles", busy_cnt, 51200);
    chk("l0 writes", l0_cnt, 4096);
    chk("l0 order", l0_err, 0);
    chk("l1 writes", l1_cnt, 1024);
    chk("l1 order", l1_err, 0);
    chk("cwr protocol", proto_err, 0);
    chk("mac_en cycles", mac_cnt, 36864);
    chk("mac_clr cycles", mclr_cnt, 4096);
    chk("pool_en cycles", pool_cnt, 4096);
    chk("pool_clr cycles", pclr_cnt, 1024);

    // ready still high: new frame starts on the very next edge.
    f0 = 51201;
    goto_edge(f0);
    chk("restart busy", busy, 1);
    chk("restart iaddr t0", iaddr, 0);
    goto_edge(f0 + 11 + 5);
    chk("f2 px0_1 iaddr t5", iaddr, 2);

    // Async reset in the middle of a C_FETCH.
    goto_edge(f0 + 14);
    chk("pre-rst mac_en", mac_en, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst cwr", cwr, 0);
    chk("mid rst crd", crd, 0);
    chk("mid rst mac_en", mac_en, 0);
    chk("mid rst csel", csel, 0);
    chk("mid rst iaddr", iaddr, 0);
    chk("mid rst tap_idx", tap_idx, 0);
    step();
    chk("in rst busy", busy, 0);
    ready = 1'b0;
    reset = 1'b1;
    step();
    chk("post rst idle", busy, 0);

    ready = 1'b1;
    step();
    ready = 1'b0;
    g0 = cyc;
    chk("rerun busy", busy, 1);
    chk("rerun iaddr t0", iaddr, 0);
    goto_edge(g0 + 1);
    chk("rerun tap_idx t0", tap_idx, 0);
    chk("rerun mac_clr t0", mac_clr, 1);
    goto_edge(g0 + 5);
    chk("rerun iaddr t5", iaddr, 1);
    goto_edge(g0 + 10);
    chk("rerun wb cwr", cwr, 1);
    chk("rerun wb caddr_wr", caddr_wr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
